gate_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the basic-gate library. On START it drives every input combination into one gate under test (NOT, AND, OR, XOR, NAND, …), waits a programmable settle time and samples the gate output. It compares each sample against a caller-supplied truth table and reports pass/fail, the error count and the first failing vector. It replaces hand-written per-gate stimulus sequences with one reusable controller that wraps any gate module.

---
 rtl/gate_bist_ctrl_if.sv | 27 ++
 rtl/gate_bist_ctrl.sv | 104 ++++++++++
 tb/tb_gate_bist_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_ctrl_if.sv
// Gate BIST controller bus: run control, gate stimulus/response and results.
// The slave side is the controller; the master side owns START/TRUTH and the gate.
interface gate_bist_ctrl_if #(
  parameter int N_IN = 2
);
  logic                 START;
  logic [2**N_IN-1:0]   TRUTH;
  logic [N_IN-1:0]      DUT_IN;
  logic                 DUT_OUT;
  logic                 BUSY;
  logic                 DONE;
  logic                 PASS;
  logic [N_IN:0]        ERR_CNT;
  logic [N_IN-1:0]      FAIL_VEC;

  modport master (
    output START, TRUTH, DUT_OUT,
    input  DUT_IN, BUSY, DONE, PASS,
    input  ERR_CNT, FAIL_VEC
  );

  modport slave (
    input  START, TRUTH, DUT_OUT,
    output DUT_IN, BUSY, DONE, PASS,
    output ERR_CNT, FAIL_VEC
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive truth-table BIST sequencer for a single basic gate.
// Each vector is held SETTLE cycles, then compared in one CHECK cycle.
module gate_bist_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  gate_bist_ctrl_if.slave bus
);
  localparam int NV = 2**N_IN;
  localparam logic [N_IN-1:0] LAST = '1;
  localparam logic [3:0] CNT_END = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state;
  logic [NV-1:0]   truth_q;
  logic [N_IN-1:0] vec;
  logic [3:0]      cnt;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] fail_vec;

  logic            miss;
  logic [N_IN:0]   err_nxt;

  assign miss    = bus.DUT_OUT != truth_q[vec];
  assign err_nxt = err_cnt + {{N_IN{1'b0}}, miss};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      truth_q  <= '0;
      vec      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.START) begin
            truth_q  <= bus.TRUTH;
            vec      <= '0;
            cnt      <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
            fail_vec <= '0;
            busy     <= 1'b1;
            state    <= S_APPLY;
          end
        end
        S_APPLY: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_END)
            state <= S_CHECK;
        end
        S_CHECK: begin
          cnt <= '0;
          if (miss) begin
            err_cnt <= err_nxt;
            if (err_cnt == '0)
              fail_vec <= vec;
          end
          // vec doubles as DUT_IN, so parking it at 0 frees the gate
          if (vec == LAST) begin
            vec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
            state <= S_DONE;
          end else begin
            vec   <= vec + 1'b1;
            state <= S_APPLY;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.DUT_IN   = vec;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.PASS     = pass;
  assign bus.ERR_CNT  = err_cnt;
  assign bus.FAIL_VEC = fail_vec;
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: NOT, AND, XOR, OR runs,
// slow settle, mid-run START/TRUTH changes and mid-run reset.
module tb_gate_bist_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;
  int   g2 = 0;

  always #5 clk = ~clk;

  gate_bist_ctrl_if #(.N_IN(1)) b1 ();
  gate_bist_ctrl_if #(.N_IN(2)) b2 ();
  gate_bist_ctrl_if #(.N_IN(2)) b3 ();

  gate_bist_ctrl #(.N_IN(1), .SETTLE(1)) u_not (
    .CLK(clk), .RST_N(rst_n), .bus(b1.slave)
  );
  gate_bist_ctrl #(.N_IN(2), .SETTLE(1)) u_g2 (
    .CLK(clk), .RST_N(rst_n), .bus(b2.slave)
  );
  gate_bist_ctrl #(.N_IN(2), .SETTLE(3)) u_slow (
    .CLK(clk), .RST_N(rst_n), .bus(b3.slave)
  );

  assign b1.DUT_OUT = ~b1.DUT_IN[0];
  assign b3.DUT_OUT = b3.DUT_IN[0] & b3.DUT_IN[1];

  always_comb begin
    b2.DUT_OUT = 1'b0;
    case (g2)
      0: b2.DUT_OUT = b2.DUT_IN[0] & b2.DUT_IN[1];
      1: b2.DUT_OUT = 1'b1;
      2: b2.DUT_OUT = b2.DUT_IN[1] ^ b2.DUT_IN[0];
      3: b2.DUT_OUT = b2.DUT_IN[0] | b2.DUT_IN[1];
      default: b2.DUT_OUT = 1'b0;
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start2(input logic [3:0] t);
    b2.TRUTH = t;
    b2.START = 1'b1;
    tick();
    b2.START = 1'b0;
  endtask

  task automatic wait_done2(input int c0, output int dc);
    int c;
    c = c0;
    dc = -1;
    while (dc < 0 && c < c0 + 64) begin
      tick();
      c++;
      if (b2.DONE) dc = c;
    end
  endtask

  initial begin
    int dc;
    int bad;
    int nbusy;
    b1.START = 1'b0; b1.TRUTH = '0;
    b2.START = 1'b0; b2.TRUTH = '0;
    b3.START = 1'b0; b3.TRUTH = '0;
    rst_n = 1'b0;
    tick();
    b2.START = 1'b1;
    tick();
    b2.START = 1'b0;
    check("rst_dut_in", int'(b2.DUT_IN), 0);
    check("rst_busy", int'(b2.BUSY), 0);
    check("rst_done", int'(b2.DONE), 0);
    check("rst_pass", int'(b2.PASS), 0);
    check("rst_err", int'(b2.ERR_CNT), 0);
    check("rst_fvec", int'(b2.FAIL_VEC), 0);
    rst_n = 1'b1;
    tick();

    // NOT gate, N_IN=1
    b1.TRUTH = 2'b01;
    b1.START = 1'b1;
    tick();
    b1.START = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (b1.DUT_IN !== 1'(k / 2) || !b1.BUSY || b1.DONE) bad++;
      tick();
    end
    check("not_seq", bad, 0);
    check("not_done", int'(b1.DONE), 1);
    check("not_busy", int'(b1.BUSY), 0);
    check("not_pass", int'(b1.PASS), 1);
    check("not_err", int'(b1.ERR_CNT), 0);
    check("not_fvec", int'(b1.FAIL_VEC), 0);
    check("not_dut_in", int'(b1.DUT_IN), 0);
    tick();
    check("not_done_pulse", int'(b1.DONE), 0);
    check("not_pass_hold", int'(b1.PASS), 1);

    // AND gate, correct
    g2 = 0;
    start2(4'b1000);
    check("and_busy0", int'(b2.BUSY), 1);
    wait_done2(0, dc);
    check("and_done_cyc", dc, 8);
    check("and_pass", int'(b2.PASS), 1);
    check("and_err", int'(b2.ERR_CNT), 0);
    tick();

    // output stuck at 1 against AND table
    g2 = 1;
    start2(4'b1000);
    wait_done2(0, dc);
    check("stk_done_cyc", dc, 8);
    check("stk_pass", int'(b2.PASS), 0);
    check("stk_err", int'(b2.ERR_CNT), 3);
    check("stk_fvec", int'(b2.FAIL_VEC), 0);
    tick();

    // XOR with swapped inputs
    g2 = 2;
    start2(4'b0110);
    wait_done2(0, dc);
    check("xor_pass", int'(b2.PASS), 1);
    check("xor_err", int'(b2.ERR_CNT), 0);
    tick();

    // OR against XOR table
    g2 = 3;
    start2(4'b0110);
    wait_done2(0, dc);
    check("or_pass", int'(b2.PASS), 0);
    check("or_err", int'(b2.ERR_CNT), 1);
    check("or_fvec", int'(b2.FAIL_VEC), 3);
    tick();

    // START re-pulse at cycle 5, TRUTH change at cycle 6
    g2 = 0;
    start2(4'b1000);
    for (int k = 0; k < 4; k++) tick();
    b2.START = 1'b1;
    tick();
    b2.START = 1'b0;
    b2.TRUTH = 4'b0111;
    tick();
    check("mid_busy", int'(b2.BUSY), 1);
    check("mid_dut_in", int'(b2.DUT_IN), 3);
    wait_done2(6, dc);
    check("mid_done_cyc", dc, 8);
    check("mid_pass", int'(b2.PASS), 1);
    check("mid_err", int'(b2.ERR_CNT), 0);
    tick();

    // reset mid-run
    g2 = 1;
    start2(4'b1000);
    for (int k = 0; k < 3; k++) tick();
    check("arst_err_pre", int'(b2.ERR_CNT), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("arst_dut_in", int'(b2.DUT_IN), 0);
    check("arst_busy", int'(b2.BUSY), 0);
    check("arst_done", int'(b2.DONE), 0);
    check("arst_pass", int'(b2.PASS), 0);
    check("arst_err", int'(b2.ERR_CNT), 0);
    check("arst_fvec", int'(b2.FAIL_VEC), 0);
    tick();
    tick();
    check("arst_idle", int'(b2.BUSY), 0);
    g2 = 2;
    start2(4'b0110);
    wait_done2(0, dc);
    check("rerun_done_cyc", dc, 8);
    check("rerun_pass", int'(b2.PASS), 1);
    check("rerun_err", int'(b2.ERR_CNT), 0);
    tick();

    // SETTLE=3 AND run
    b3.TRUTH = 4'b1000;
    b3.START = 1'b1;
    tick();
    b3.START = 1'b0;
    bad = 0;
    nbusy = 0;
    for (int c = 0; c < 16; c++) begin
      if (b3.BUSY) nbusy++;
      if (b3.DUT_IN !== 2'(c / 4) || b3.DONE) bad++;
      tick();
    end
    check("slow_hold", bad, 0);
    check("slow_busy_cycles", nbusy, 16);
    check("slow_done", int'(b3.DONE), 1);
    check("slow_busy_end", int'(b3.BUSY), 0);
    check("slow_pass", int'(b3.PASS), 1);
    tick();
    check("slow_done_pulse", int'(b3.DONE), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
